// File: rtl/sp_ram_arb_if.sv
// sp_ram_arb_if: bundle of every non-clock signal of sp_ram_arb.
//
// Requester side (one set per requester, prefix a_ / b_):
//   *_req, *_we, *_addr, *_din   command from the requester
//   *_ready                      command accepted this cycle (combinational)
//   *_rvalid                     rdata carries this requester's read response
// Shared:
//   rdata                        read response data (straight from ram_dout)
// RAM side:
//   ram_we, ram_addr, ram_din    registered command to the RAM
//   ram_dout                     RAM read data
// Observability:
//   dbg_prio_b                   1 when the priority pointer favours B
//   dbg_tags_busy                1 while any read tag is in flight
//
// Handshake: a command transfers in the cycle where req && ready are both
// high. The requester keeps req/we/addr/din stable until that cycle; the
// arbiter never stores an ungranted command. Responses carry no
// back-pressure: *_rvalid is a one-cycle strobe that must be consumed.
//
// Modports: slave = the arbiter, master = the clients plus the RAM.

interface sp_ram_arb_if #(
  parameter int D_WIDTH = 72,
  parameter int A_WIDTH = 10
);

  logic               a_req;
  logic               a_we;
  logic [A_WIDTH-1:0] a_addr;
  logic [D_WIDTH-1:0] a_din;
  logic               a_ready;
  logic               a_rvalid;

  logic               b_req;
  logic               b_we;
  logic [A_WIDTH-1:0] b_addr;
  logic [D_WIDTH-1:0] b_din;
  logic               b_ready;
  logic               b_rvalid;

  logic [D_WIDTH-1:0] rdata;

  logic               ram_we;
  logic [A_WIDTH-1:0] ram_addr;
  logic [D_WIDTH-1:0] ram_din;
  logic [D_WIDTH-1:0] ram_dout;

  logic               dbg_prio_b;
  logic               dbg_tags_busy;

  modport slave (
    input  a_req, a_we, a_addr, a_din,
    input  b_req, b_we, b_addr, b_din,
    input  ram_dout,
    output a_ready, a_rvalid,
    output b_ready, b_rvalid,
    output rdata,
    output ram_we, ram_addr, ram_din,
    output dbg_prio_b, dbg_tags_busy
  );

  modport master (
    output a_req, a_we, a_addr, a_din,
    output b_req, b_we, b_addr, b_din,
    output ram_dout,
    input  a_ready, a_rvalid,
    input  b_ready, b_rvalid,
    input  rdata,
    input  ram_we, ram_addr, ram_din,
    input  dbg_prio_b, dbg_tags_busy
  );

endinterface

// File: rtl/sp_ram_arb.sv
// sp_ram_arb: two-requester round-robin arbiter and command sequencer for a
// single-port, read-before-write block RAM with LATENCY cycles of read
// latency (LATENCY >= 1).
//
// Ports:
//   clk   single clock, everything on posedge
//   rst   asynchronous active-high reset
//   bus   sp_ram_arb_if.slave: requester commands/handshakes, shared rdata,
//         registered RAM command, RAM read data, debug observability
//
// Timing for a command accepted in cycle n:
//   - the RAM sees it on ram_* in cycle n+1
//   - a read returns with its rvalid strobe and rdata in cycle n+1+LATENCY
// One command per cycle in total; responses return in acceptance order.

module sp_ram_arb #(
  parameter int D_WIDTH = 72,
  parameter int A_WIDTH = 10,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  sp_ram_arb_if.slave  bus
);

  // Priority pointer: which side wins when both request.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  // Read tag: bit 1 = read issued by A, bit 0 = read issued by B.
  typedef logic [1:0] tag_t;

  prio_e                prio_q, prio_d;
  logic                 ram_we_q, ram_we_d;
  logic [A_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [D_WIDTH-1:0]   ram_din_q, ram_din_d;
  // Stage 0 holds the tag of the command the RAM is executing this cycle;
  // stage LATENCY lines up with the cycle its data is on ram_dout.
  tag_t [LATENCY:0]     tag_q, tag_d;

  logic                 a_grant;
  logic                 b_grant;
  tag_t                 new_tag;

  // ------------------------------------------------------------------
  // Arbitration. Grants are forced low while rst is high so that a
  // requester cannot believe a command was taken during reset.
  // ------------------------------------------------------------------
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (!rst) begin
      a_grant = bus.a_req & (~bus.b_req | (prio_q == PRIO_A));
      b_grant = bus.b_req & (~bus.a_req | (prio_q == PRIO_B));
    end
  end

  assign bus.a_ready = a_grant;
  assign bus.b_ready = b_grant;

  // ------------------------------------------------------------------
  // Next state: priority pointer, RAM command register, tag pipeline.
  // After any grant the pointer moves to the side that did not win; this
  // covers both the contended case (strict alternation) and the
  // single-requester case.
  // ------------------------------------------------------------------
  always_comb begin
    prio_d     = prio_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    new_tag    = 2'b00;

    if (a_grant) begin
      prio_d     = PRIO_B;
      ram_we_d   = bus.a_we;
      ram_addr_d = bus.a_addr;
      ram_din_d  = bus.a_din;
      new_tag    = {~bus.a_we, 1'b0};
    end else if (b_grant) begin
      prio_d     = PRIO_A;
      ram_we_d   = bus.b_we;
      ram_addr_d = bus.b_addr;
      ram_din_d  = bus.b_din;
      new_tag    = {1'b0, ~bus.b_we};
    end

    // Writes and idle cycles push 00, so read-before-write data on
    // ram_dout is never flagged.
    tag_d = {tag_q[LATENCY-1:0], new_tag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= PRIO_A;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      tag_q      <= '0;
    end else begin
      prio_q     <= prio_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      tag_q      <= tag_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;

  assign bus.rdata    = bus.ram_dout;
  assign bus.a_rvalid = tag_q[LATENCY][1];
  assign bus.b_rvalid = tag_q[LATENCY][0];

  assign bus.dbg_prio_b    = (prio_q == PRIO_B);
  assign bus.dbg_tags_busy = |tag_q;

  // ------------------------------------------------------------------
  // Invariants: at most one grant and at most one response strobe.
  // ------------------------------------------------------------------
  a_one_grant : assert property (@(posedge clk) disable iff (rst)
    !(bus.a_ready && bus.b_ready));

  a_one_rvalid : assert property (@(posedge clk) disable iff (rst)
    !(bus.a_rvalid && bus.b_rvalid));

endmodule

// File: tb/tb_sp_ram_arb.sv
// tb_sp_ram_arb: self-checking bench for sp_ram_arb.
// Main instance uses LATENCY=2 with a behavioural read-before-write RAM;
// a second instance uses LATENCY=4 to check response timing only.

module tb_sp_ram_arb;

  localparam int D_W   = 72;
  localparam int A_W   = 10;
  localparam int LAT   = 2;
  localparam int LAT4  = 4;
  localparam int DEPTH = 1 << A_W;

  typedef struct packed {
    logic           req;
    logic           we;
    logic [A_W-1:0] addr;
    logic [D_W-1:0] din;
  } cmd_t;

  typedef struct {
    cmd_t a;
    cmd_t b;
    logic exp_ar;
    logic exp_br;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  sp_ram_arb_if #(.D_WIDTH(D_W), .A_WIDTH(A_W)) bus  ();
  sp_ram_arb_if #(.D_WIDTH(D_W), .A_WIDTH(A_W)) bus4 ();

  sp_ram_arb #(.D_WIDTH(D_W), .A_WIDTH(A_W), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sp_ram_arb #(.D_WIDTH(D_W), .A_WIDTH(A_W), .LATENCY(LAT4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  // ---------------- behavioural RAM for the main instance ----------------
  function automatic logic [D_W-1:0] pattern(input int i);
    return {8'hC3, 32'(i * 7 + 1), 32'(i)};
  endfunction

  logic [D_W-1:0] mem [0:DEPTH-1];
  logic [D_W-1:0] dpipe [0:LAT-1];
  bit             mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pattern(i);
      mem_init_done <= 1'b1;
    end else begin
      dpipe[0] <= mem[bus.ram_addr];
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    end
  end

  assign bus.ram_dout  = dpipe[LAT-1];
  assign bus4.ram_dout = {D_W{1'b1}};

  // ---------------- reference model and scoreboard ----------------
  int             checks = 0;
  int             errors = 0;
  int             cyc    = 0;

  logic [D_W-1:0] m_mem [0:DEPTH-1];
  bit             m_prio_b;
  logic           m_ram_we;
  logic [A_W-1:0] m_ram_addr;
  logic [D_W-1:0] m_ram_din;
  logic [D_W-1:0] exp_q [$];
  int             due_q [$];
  bit             who_q [$];

  task automatic check(input string name, input logic [D_W-1:0] act, input logic [D_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_prio_b   = 1'b0;
    m_ram_we   = 1'b0;
    m_ram_addr = '0;
    m_ram_din  = '0;
    exp_q.delete();
    due_q.delete();
    who_q.delete();
  endtask

  // Accepted command: writes land in the model memory at once, reads
  // capture the model memory now and are due 1+LAT cycles later.
  task automatic model_accept(input cmd_t c, input bit side_b);
    m_ram_we   = c.we;
    m_ram_addr = c.addr;
    m_ram_din  = c.din;
    if (c.we) begin
      m_mem[c.addr] = c.din;
    end else begin
      exp_q.push_back(m_mem[c.addr]);
      due_q.push_back(cyc + 1 + LAT);
      who_q.push_back(side_b);
    end
    m_prio_b = !side_b;
  endtask

  // ---------------- driver tasks ----------------
  function automatic cmd_t idle();
    cmd_t c;
    c = '0;
    return c;
  endfunction

  function automatic cmd_t rd(input int addr);
    cmd_t c;
    c      = '0;
    c.req  = 1'b1;
    c.addr = A_W'(addr);
    return c;
  endfunction

  function automatic cmd_t wr(input int addr, input logic [D_W-1:0] d);
    cmd_t c;
    c      = '0;
    c.req  = 1'b1;
    c.we   = 1'b1;
    c.addr = A_W'(addr);
    c.din  = d;
    return c;
  endfunction

  task automatic drive_cmds(input cmd_t a, input cmd_t b);
    bus.a_req  = a.req;
    bus.a_we   = a.we;
    bus.a_addr = a.addr;
    bus.a_din  = a.din;
    bus.b_req  = b.req;
    bus.b_we   = b.we;
    bus.b_addr = b.addr;
    bus.b_din  = b.din;
  endtask

  // One cycle: drive just after posedge, check at negedge, update model.
  task automatic step(input cmd_t a, input cmd_t b,
                      output bit ga, output bit gb,
                      output logic act_ar, output logic act_br);
    bit due;
    drive_cmds(a, b);
    @(negedge clk);
    ga = a.req && (!b.req || !m_prio_b);
    gb = b.req && (!a.req || m_prio_b);
    act_ar = bus.a_ready;
    act_br = bus.b_ready;
    check_bit("a_ready", bus.a_ready, ga);
    check_bit("b_ready", bus.b_ready, gb);
    check_bit("ram_we", bus.ram_we, m_ram_we);
    check("ram_addr", D_W'(bus.ram_addr), D_W'(m_ram_addr));
    check("ram_din", bus.ram_din, m_ram_din);
    check_bit("prio_b", bus.dbg_prio_b, m_prio_b);
    due = (due_q.size() > 0) && (due_q[0] == cyc);
    check_bit("a_rvalid", bus.a_rvalid, due && !who_q[0]);
    check_bit("b_rvalid", bus.b_rvalid, due && who_q[0]);
    if (due) begin
      check("rdata", bus.rdata, exp_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
      void'(who_q.pop_front());
    end
    if (ga)      model_accept(a, 1'b0);
    else if (gb) model_accept(b, 1'b1);
    else         m_ram_we = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n, input cmd_t a);
    drive_cmds(a, idle());
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_bit("rst_a_ready", bus.a_ready, 1'b0);
      check_bit("rst_b_ready", bus.b_ready, 1'b0);
      check_bit("rst_ram_we", bus.ram_we, 1'b0);
      check("rst_ram_addr", D_W'(bus.ram_addr), '0);
      check("rst_ram_din", bus.ram_din, '0);
      check_bit("rst_a_rvalid", bus.a_rvalid, 1'b0);
      check_bit("rst_b_rvalid", bus.b_rvalid, 1'b0);
      check_bit("rst_tags", bus.dbg_tags_busy, 1'b0);
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [$];

  initial begin
    bit   ga, gb;
    logic ar, br;
    cmd_t pa, pb;

    for (int i = 0; i < DEPTH; i++) m_mem[i] = pattern(i);
    model_reset();
    drive_cmds(idle(), idle());
    bus4.a_req = 1'b0; bus4.a_we = 1'b0; bus4.a_addr = '0; bus4.a_din = '0;
    bus4.b_req = 1'b0; bus4.b_we = 1'b0; bus4.b_addr = '0; bus4.b_din = '0;

    @(posedge clk);
    #1;

    // Reset held with A requesting; the first post-reset cycle is vector 0.
    do_reset(2, wr(3, 72'h5A));

    // Directed table: write/read hazard, contention, B write stream.
    vecs.push_back('{wr(3, 72'h5A), idle(),  1'b1, 1'b0});
    vecs.push_back('{rd(3),         idle(),  1'b1, 1'b0});
    vecs.push_back('{rd(0),         rd(10),  1'b0, 1'b1});
    vecs.push_back('{rd(0),         rd(11),  1'b1, 1'b0});
    vecs.push_back('{rd(1),         rd(11),  1'b0, 1'b1});
    vecs.push_back('{rd(1),         rd(12),  1'b1, 1'b0});
    vecs.push_back('{rd(2),         rd(12),  1'b0, 1'b1});
    vecs.push_back('{rd(2),         rd(13),  1'b1, 1'b0});
    vecs.push_back('{rd(3),         rd(13),  1'b0, 1'b1});
    vecs.push_back('{rd(3),         idle(),  1'b1, 1'b0});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{idle(), wr(20 + i, D_W'(72'h1000 + i)), 1'b0, 1'b1});
    vecs.push_back('{rd(20),        idle(),  1'b1, 1'b0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{idle(), idle(), 1'b0, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, ga, gb, ar, br);
      check_bit("vec_a_ready", ar, vecs[i].exp_ar);
      check_bit("vec_b_ready", br, vecs[i].exp_br);
    end

    // Reset with two reads in flight: nothing may come back afterwards.
    step(rd(5), idle(), ga, gb, ar, br);
    step(idle(), rd(6), ga, gb, ar, br);
    do_reset(1, idle());
    for (int i = 0; i < 6; i++) step(idle(), idle(), ga, gb, ar, br);

    // Randomized traffic with hold-until-ready requesters.
    pa = idle();
    pb = idle();
    for (int i = 0; i < 500; i++) begin
      if (!pa.req && $urandom_range(0, 99) < 60) begin
        if ($urandom_range(0, 2) == 0)
          pa = wr($urandom_range(0, 15), D_W'({$urandom(), $urandom(), $urandom()}));
        else
          pa = rd($urandom_range(0, 15));
      end
      if (!pb.req && $urandom_range(0, 99) < 60) begin
        if ($urandom_range(0, 2) == 0)
          pb = wr($urandom_range(0, 15), D_W'({$urandom(), $urandom(), $urandom()}));
        else
          pb = rd($urandom_range(0, 15));
      end
      step(pa, pb, ga, gb, ar, br);
      if (ga) pa = idle();
      if (gb) pb = idle();
    end
    for (int i = 0; i < LAT + 4; i++) step(idle(), idle(), ga, gb, ar, br);
    check("drain_pending", D_W'(exp_q.size()), '0);

    // LATENCY=4 instance: one A read at cycle 0, strobe only in cycle 5.
    rst4 = 1'b0;
    @(posedge clk);
    #1;
    bus4.a_req  = 1'b1;
    bus4.a_we   = 1'b0;
    bus4.a_addr = A_W'(7);
    @(negedge clk);
    check_bit("l4_a_ready", bus4.a_ready, 1'b1);
    @(posedge clk);
    #1;
    bus4.a_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_bit("l4_a_rvalid", bus4.a_rvalid, k == 5);
      check_bit("l4_b_rvalid", bus4.b_rvalid, 1'b0);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
